mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//   Round-robin arbiter/scheduler that shares one registered 4:1 datapath mux between four requesters.
//   Picks a requester, drives sel/gnt, registers the chosen input and presents it on a valid/ready
//   output port. A grant may be held for a bounded burst of beats before the arbiter re-arbitrates.
//   Sits between the four source agents and the downstream consumer of the muxed word y.
// PARAMETERS
//   WIDTH      4   data width of I0..I3 and y
//   MAX_BURST  4   max beats per grant before forced re-arbitration (>=1)
//   BURST_W    $clog2(MAX_BURST+1)   beat-counter width (derived, do not override)
// PORTS
//   clk      in   1      single clock, rising edge
//   rst      in   1      synchronous reset, active-high
//   req      in   4      req[i]=1: requester i has a word on Ii
//   I0..I3   in   WIDTH  requester data inputs
//   gnt      out  4      one-hot grant, 0 when idle
//   sel      out  2      index of current grant (mux select)
//   y        out  WIDTH  registered selected data
//   y_valid  out  1      y holds a beat not yet accepted
//   y_ready  in   1      downstream accepts y when y_valid&y_ready (transfer)
//   busy     out  1      state==SERVE
// BEHAVIOUR
//   Reset (sync, rst=1 at edge): state=IDLE, gnt=0, sel=0, y=0, y_valid=0, beat_cnt=0, last=3
//     (so req0 has highest priority first). rst mid-burst drops the in-flight beat; no partial output.
//   Priority: rotate from last+1 mod 4; first set req bit wins. last updates only on grant release.
//   IDLE: if |req at edge t -> gnt=onehot(win), sel=win, y=I[win], y_valid=1, beat_cnt=0,
//     state=SERVE, all visible at t+1 (latency 1 cycle). No req -> stay IDLE, outputs hold.
//   SERVE, no transfer (y_ready=0): y, y_valid, sel, gnt held stable; req changes ignored.
//   SERVE, transfer at edge:
//     - continue if req[sel]=1 and beat_cnt+1<MAX_BURST: y=I[sel], beat_cnt++, y_valid stays 1
//       (back-to-back, no bubble).
//     - else release: last=sel; if |req, re-arbitrate same edge from sel+1 (current requester may
//       win again if alone), load new y/sel/gnt, beat_cnt=0, stay SERVE, no bubble;
//       if req==0 -> IDLE, gnt=0, y_valid=0, y holds last value, sel holds.
//   req[sel] dropping while y_valid=1 and not accepted: beat still delivered; release at transfer.
//   Data sampled only on the loading edge; Ii changes afterwards do not alter y.
//   Invariants: gnt onehot0; gnt!=0 <-> state==SERVE <-> y_valid; beat_cnt<MAX_BURST.
//   MAX_BURST=1 gives pure per-beat round robin.
// STRUCTURE
//   Package mux_arb_pkg: state enum {IDLE,SERVE}, N_REQ=4, SEL_W=2, onehot4() function.
//   Sub-module rr_pick4 (combinational): inputs req[3:0], last[1:0]; outputs win[1:0], found.
//   Top holds FSM, beat counter, last pointer, y/y_valid/sel/gnt registers and data mux.
// TESTING
//   1. rst=1 two cycles -> y=0,y_valid=0,gnt=0,sel=0,busy=0; rst=0, req=0 -> all hold.
//   2. req=4'b1111, I0..I3=1,2,3,4, y_ready=1, MAX_BURST=1 -> y sequence 1,2,3,4,1 on consecutive
//      cycles, gnt 0001,0010,0100,1000,0001, no bubbles.
//   3. req=4'b0100 only, MAX_BURST=4, y_ready=1 -> 4 beats of I2 per grant, re-grant to 2 with no
//      bubble, beat_cnt wraps 0..3.
//   4. Grant to req0, y=1, hold y_ready=0 five cycles while I0 changes to 9 and req0 drops ->
//      y stays 1, y_valid=1; y_ready=1 -> transfer, then IDLE (gnt=0, y_valid=0).
//   5. req=4'b1001 after last=3, MAX_BURST=2 -> grant 0 two beats, then 3 two beats, then 0.
//   6. rst=1 mid-burst with y_valid=1 -> next cycle all reset values; after release, req=4'b1000
//      -> grant 3 (priority restarts from req0, only req3 active).

Source files
------------

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types and helpers for the round-robin mux arbiter
package mux_arb_pkg;
   typedef enum logic {IDLE, SERVE} state_t;
   localparam int N_REQ = 4;
   localparam int SEL_W = 2;
   function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] i);
      return N_REQ'(1) << i;
   endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: first set request bit searching upward from last+1, wrapping mod 4
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] last,
   output logic [SEL_W-1:0] win,
   output logic             found
);
   always_comb begin
      win = '0;
      found = 1'b0;
      // scanned farthest-first so the nearest requester overwrites last
      for (int k = N_REQ; k >= 1; k--) begin
         if (req[last + SEL_W'(k)]) begin
            win = last + SEL_W'(k);
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin scheduler sharing one registered 4:1 mux between four
// requesters, with bounded bursts per grant and a valid/ready output port
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic [WIDTH-1:0] I2,
   input  logic [WIDTH-1:0] I3,
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
   input  logic             y_ready,
   output logic             busy
);
   localparam int BURST_W = $clog2(MAX_BURST + 1);
   state_t state, state_n;
   logic [N_REQ-1:0] gnt_n;
   logic [SEL_W-1:0] sel_n, last, last_n, ptr, win;
   logic [WIDTH-1:0] y_n;
   logic [BURST_W-1:0] beat_cnt, beat_cnt_n, bc_inc;
   logic y_valid_n, found, xfer;
   logic [WIDTH-1:0] din [N_REQ];
   assign din[0] = I0;
   assign din[1] = I1;
   assign din[2] = I2;
   assign din[3] = I3;
   assign busy = state == SERVE;
   assign xfer = y_valid & y_ready;
   assign bc_inc = beat_cnt + BURST_W'(1);
   // on release the search starts after the requester just served
   assign ptr = (state == SERVE) ? sel : last;
   rr_pick4 u_pick (.req(req), .last(ptr), .win(win), .found(found));
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt <= '0;
         sel <= '0;
         y <= '0;
         y_valid <= 1'b0;
         beat_cnt <= '0;
         last <= SEL_W'(N_REQ - 1);
      end else begin
         state <= state_n;
         gnt <= gnt_n;
         sel <= sel_n;
         y <= y_n;
         y_valid <= y_valid_n;
         beat_cnt <= beat_cnt_n;
         last <= last_n;
      end
   end
   always_comb begin
      state_n = state;
      gnt_n = gnt;
      sel_n = sel;
      y_n = y;
      y_valid_n = y_valid;
      beat_cnt_n = beat_cnt;
      last_n = last;
      if (state == SERVE && xfer && req[sel] && bc_inc < BURST_W'(MAX_BURST)) begin
         y_n = din[sel];
         beat_cnt_n = bc_inc;
      end else if (state == IDLE || xfer) begin
         if (state == SERVE) last_n = sel;
         if (found) begin
            state_n = SERVE;
            gnt_n = onehot4(win);
            sel_n = win;
            y_n = din[win];
            y_valid_n = 1'b1;
            beat_cnt_n = '0;
         end else begin
            state_n = IDLE;
            gnt_n = '0;
            y_valid_n = 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed checks of three arbiter instances (MAX_BURST 1, 2, 4)
// driven from shared inputs
module tb_mux_rr_arbiter;
   logic clk = 1'b0, rst = 1'b1, y_ready = 1'b0;
   logic [3:0] req = '0, I0 = '0, I1 = '0, I2 = '0, I3 = '0;
   logic [3:0] gnt1, gnt2, gnt4, y1, y2, y4;
   logic [1:0] sel1, sel2, sel4;
   logic yv1, yv2, yv4, busy1, busy2, busy4;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   mux_rr_arbiter #(.WIDTH(4), .MAX_BURST(1)) d1 (.clk(clk), .rst(rst), .req(req), .I0(I0), .I1(I1),
      .I2(I2), .I3(I3), .gnt(gnt1), .sel(sel1), .y(y1), .y_valid(yv1), .y_ready(y_ready), .busy(busy1));
   mux_rr_arbiter #(.WIDTH(4), .MAX_BURST(2)) d2 (.clk(clk), .rst(rst), .req(req), .I0(I0), .I1(I1),
      .I2(I2), .I3(I3), .gnt(gnt2), .sel(sel2), .y(y2), .y_valid(yv2), .y_ready(y_ready), .busy(busy2));
   mux_rr_arbiter #(.WIDTH(4), .MAX_BURST(4)) d4 (.clk(clk), .rst(rst), .req(req), .I0(I0), .I1(I1),
      .I2(I2), .I3(I3), .gnt(gnt4), .sel(sel4), .y(y4), .y_valid(yv4), .y_ready(y_ready), .busy(busy4));
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic reset_all();
      rst = 1'b1;
      req = '0;
      y_ready = 1'b0;
      step();
      rst = 1'b0;
   endtask
   initial begin
      logic [3:0] ey [5];
      logic [3:0] eg [5];
      logic [1:0] es [5];
      // 1: reset and idle hold
      step();
      step();
      chk("rst_y", y1, 0);
      chk("rst_yv", yv1, 0);
      chk("rst_gnt", gnt1, 0);
      chk("rst_sel", sel1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_gnt4", gnt4, 0);
      rst = 1'b0;
      step();
      step();
      chk("idle_gnt", gnt1, 0);
      chk("idle_yv", yv1, 0);
      chk("idle_busy", busy1, 0);
      // 2: MAX_BURST=1 pure round robin
      I0 = 4'd1; I1 = 4'd2; I2 = 4'd3; I3 = 4'd4;
      req = 4'b1111;
      y_ready = 1'b1;
      ey = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
      eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("rr_y%0d", i), y1, ey[i]);
         chk($sformatf("rr_gnt%0d", i), gnt1, eg[i]);
         chk($sformatf("rr_yv%0d", i), yv1, 1);
      end
      reset_all();
      // 3: single requester, bursts of 4 with fresh data each beat
      req = 4'b0100;
      y_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         I2 = 4'(i + 5);
         step();
         chk($sformatf("bu_y%0d", i), y4, i + 5);
         chk($sformatf("bu_gnt%0d", i), gnt4, 4'b0100);
         chk($sformatf("bu_cnt%0d", i), d4.beat_cnt, i % 4);
         chk($sformatf("bu_yv%0d", i), yv4, 1);
      end
      reset_all();
      // 4: backpressure holds the beat while data and req change
      I0 = 4'd1;
      req = 4'b0001;
      y_ready = 1'b0;
      step();
      I0 = 4'd9;
      req = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("bp_y%0d", i), y4, 1);
         chk($sformatf("bp_yv%0d", i), yv4, 1);
         chk($sformatf("bp_gnt%0d", i), gnt4, 4'b0001);
      end
      y_ready = 1'b1;
      step();
      chk("bp_end_gnt", gnt4, 0);
      chk("bp_end_yv", yv4, 0);
      chk("bp_end_busy", busy4, 0);
      chk("bp_end_y", y4, 1);
      chk("bp_end_sel", sel4, 0);
      reset_all();
      // 5: MAX_BURST=2 alternation between req0 and req3
      I0 = 4'd1; I3 = 4'd4;
      req = 4'b1001;
      y_ready = 1'b1;
      eg = '{4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b0001};
      es = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd0};
      ey = '{4'd1, 4'd1, 4'd4, 4'd4, 4'd1};
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("b2_gnt%0d", i), gnt2, eg[i]);
         chk($sformatf("b2_sel%0d", i), sel2, es[i]);
         chk($sformatf("b2_y%0d", i), y2, ey[i]);
      end
      // d4 ran the same stimulus: four beats of req0, then req3
      chk("b4_gnt", gnt4, 4'b1000);
      chk("b4_yv", yv4, 1);
      chk("b4_cnt", d4.beat_cnt, 0);
      // 6: reset mid-burst, then priority restarts
      rst = 1'b1;
      step();
      chk("mr_y", y4, 0);
      chk("mr_yv", yv4, 0);
      chk("mr_gnt", gnt4, 0);
      chk("mr_sel", sel4, 0);
      chk("mr_busy", busy4, 0);
      rst = 1'b0;
      req = 4'b1000;
      step();
      chk("mr_regnt", gnt4, 4'b1000);
      chk("mr_resel", sel4, 3);
      chk("mr_rey", y4, 4);
      req = 4'b1111;
      reset_all();
      req = 4'b1010;
      y_ready = 1'b1;
      step();
      chk("pri_gnt", gnt1, 4'b0010);
      step();
      chk("pri_gnt2", gnt1, 4'b1000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
